spike_volley_encoder: RTL
=========================

# spike_volley_encoder

Temporal-coding front end of a column: converts a vector of per-neuron spike times into a stream of one-hot-in-time spike volleys, one period of `TIME_PERIOD` cycles per input vector. It drives the `time_val` / `spike_volley` pair consumed by the lateral inhibition stage, and takes that stage's winner indication back as an inhibit input. A one-entry pending buffer lets the next vector load while the current period runs, so periods can run back-to-back.

## Interface
- `TIME_PERIOD`, default `` `time_period `` (bench uses 8): cycles per period.
- `NEURONS`, default `` `neurons_per_layer `` (bench uses 4): volley width.
- `TW`, derived, $clog2(TIME_PERIOD)+1: spike-time field width. A value ≥ TIME_PERIOD means "no spike".

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  spike-time vector offered.
- `in_ready`  out  1  pending buffer empty.
- `in_times`  in  NEURONS*TW  packed spike times; neuron i occupies bits [i*TW +: TW].
- `inhibit`  in  1  winner found downstream; mask the remainder of the period.
- `time_val`  out  TW  current time step, 0..TIME_PERIOD-1.
- `spike_volley`  out  NEURONS  bit i high while `time_val` == time[i], active, unmasked.
- `period_start`  out  1  high in the cycle `time_val`==0 of a running period.
- `period_end`  out  1  high in the cycle `time_val`==TIME_PERIOD-1.
- `busy`  out  1  state is RUN.

## Operation
- States: IDLE and RUN.
- Registers: `active` vector, `pending` vector plus `pend_full`, `time_val`, `mask`.
- `in_ready` = !pend_full. A transfer occurs when `in_valid` && `in_ready`.
- IDLE + transfer: the vector loads into `active`. Next state is RUN with `time_val`=0 and `mask`=0.
- RUN, not last step: `time_val` increments. A transfer loads `pending` and sets `pend_full`.
- RUN, last step (`time_val`==TIME_PERIOD-1):
  - If `pend_full`: pending moves to active, `pend_full` clears, `time_val` wraps to 0, `mask` clears, state stays RUN.
  - Else if a transfer occurs this cycle: bypass the input straight into active, same as above.
  - Else: go to IDLE, `time_val`=0.
- `inhibit` sampled high in RUN sets `mask` at the edge. Spikes are suppressed from the next cycle until the period ends. `time_val` keeps counting, so periods stay aligned.
- `inhibit` in the last step has no effect, because `mask` clears on wrap.
- `spike_volley`, `period_start`, `period_end`, `busy` and `in_ready` decode from registers only. There is no combinational path from inputs to outputs.
- `spike_volley` is 0 in IDLE.
- Each neuron spikes at most once per period. Times ≥ TIME_PERIOD never spike.
- Comparison is unsigned over TW bits.

## Timing
- Reset value of every output and register is 0 or IDLE, with `pend_full`=0. `in_ready` therefore reads 1 during and after reset.
- Latency from an accepting edge in IDLE: `time_val`=0, `period_start`=1, and spikes for time 0 appear in the very next cycle.
- A period is exactly TIME_PERIOD cycles. Back-to-back periods have zero gap cycles.
- Inhibit takes effect one cycle later.
- Reset asserted mid-period: immediate return to IDLE. The pending vector is discarded. No partial volley completes.
- Pending full: `in_ready`=0 until the wrap edge. The producer must hold `in_valid` and its data stable.

## Structure
- Shared package `snn_pkg`:
  - `spike_time_t` (logic [TW-1:0]).
  - `enc_state_t` enum {IDLE, RUN}.
  - The no-spike constant `NO_SPIKE` = TIME_PERIOD.
- One natural sub-module: `spike_vector_buffer`, the one-entry pending register with valid/ready and bypass select.
- Per-neuron compare logic stays inline as a generate loop.

## Test plan
- Reset then load {3,0,7,8} in IDLE → next 8 cycles `time_val` 0..7. `spike_volley` is 0010 at t0, 0001 at t3, 0100 at t7, and nothing else. Neuron 3 never fires. `period_start` at t0, `period_end` at t7, then IDLE.
- Load A={1,1,1,1}, then load B={2,2,2,2} at t3 → `in_ready` drops at t4. Period B starts directly after A's t7 with no gap, and B fires all bits at its t2.
- Pending empty, offer a vector exactly at t7 → accepted (bypass), next cycle `time_val`=0, no IDLE cycle.
- Times {2,4,5,6}, assert `inhibit` for one cycle at t2 → only bit 0 fires at t2. No spikes at t4..t6. The counter still reaches t7 and the next period fires normally.
- Assert `rst_n`=0 at t4 with pending full → all outputs 0 immediately. After release, `in_ready`=1 and state is IDLE; the old pending vector never appears.
- All times ≥ 8 → a full 8-cycle period with `spike_volley`=0 throughout; `period_start` and `period_end` still pulse.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking column front end.
// Default sizes come from the project-wide `SNN_TIME_PERIOD / `SNN_NEURONS_PER_LAYER macros.
`ifndef SNN_TIME_PERIOD
`define SNN_TIME_PERIOD 8
`endif
`ifndef SNN_NEURONS_PER_LAYER
`define SNN_NEURONS_PER_LAYER 4
`endif

package snn_pkg;

    localparam int TIME_PERIOD = `SNN_TIME_PERIOD;
    localparam int NEURONS     = `SNN_NEURONS_PER_LAYER;
    localparam int TW          = $clog2(TIME_PERIOD) + 1;

    // Any spike time at or above the period length never fires.
    localparam int NO_SPIKE    = TIME_PERIOD;

    typedef logic [TW-1:0] spike_time_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

endpackage

// File: rtl/spike_volley_encoder_if.sv
// Producer/consumer bundle of the spike volley encoder.
// The master side offers spike-time vectors and inhibit; the slave side is the encoder.
interface spike_volley_encoder_if #(
    parameter int NEURONS = snn_pkg::NEURONS,
    parameter int TW      = snn_pkg::TW
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NEURONS*TW-1:0]   in_times;
    logic                    inhibit;
    logic [TW-1:0]           time_val;
    logic [NEURONS-1:0]      spike_volley;
    logic                    period_start;
    logic                    period_end;
    logic                    busy;

    modport master (
        output in_valid, in_times, inhibit,
        input  in_ready, time_val, spike_volley, period_start, period_end, busy
    );

    modport slave (
        input  in_valid, in_times, inhibit,
        output in_ready, time_val, spike_volley, period_start, period_end, busy
    );
endinterface

// File: rtl/spike_vector_buffer.sv
// One-entry pending register for spike-time vectors with valid/ready handshake.
// o_sel_data picks the stored vector when full, otherwise bypasses the live input.
module spike_vector_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_capture,
    input  logic         i_pop,
    output logic         o_ready,
    output logic         o_full,
    output logic [W-1:0] o_sel_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (i_capture && i_valid && !r_full) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready    = !r_full;
    assign o_full     = r_full;
    assign o_sel_data = r_full ? r_data : i_data;

endmodule

// File: rtl/spike_volley_encoder.sv
// Converts per-neuron spike times into one-hot-in-time volleys, one TIME_PERIOD per vector.
// A pending slot lets the next vector queue up so periods run back-to-back.
module spike_volley_encoder
    import snn_pkg::*;
#(
    parameter int TIME_PERIOD = snn_pkg::TIME_PERIOD,
    parameter int NEURONS     = snn_pkg::NEURONS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spike_volley_encoder_if.slave  enc
);

    localparam int TW = $clog2(TIME_PERIOD) + 1;
    localparam logic [TW-1:0] LAST_STEP = TW'(TIME_PERIOD - 1);

    enc_state_t              r_state;
    enc_state_t              w_next_state;
    logic [TW-1:0]           r_time;
    logic [TW-1:0]           w_next_time;
    logic                    r_mask;
    logic                    w_next_mask;
    logic [NEURONS*TW-1:0]   r_active;

    logic                    w_ready;
    logic                    w_full;
    logic [NEURONS*TW-1:0]   w_sel_data;
    logic                    w_transfer;
    logic                    w_last;
    logic                    w_load_active;
    logic                    w_capture;
    logic                    w_pop;
    logic [NEURONS-1:0]      w_match;

    spike_vector_buffer #(
        .W (NEURONS*TW)
    ) u_pending (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (enc.in_valid),
        .i_data     (enc.in_times),
        .i_capture  (w_capture),
        .i_pop      (w_pop),
        .o_ready    (w_ready),
        .o_full     (w_full),
        .o_sel_data (w_sel_data)
    );

    assign w_transfer = enc.in_valid && w_ready;
    assign w_last     = (r_time == LAST_STEP);

    always_comb begin
        w_next_state  = r_state;
        w_next_time   = r_time;
        w_next_mask   = r_mask;
        w_load_active = 1'b0;
        w_capture     = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_load_active = 1'b1;
                    w_next_state  = RUN;
                    w_next_time   = '0;
                    w_next_mask   = 1'b0;
                end
            end
            RUN: begin
                if (!w_last) begin
                    w_next_time = r_time + TW'(1);
                    w_capture   = 1'b1;
                    if (enc.inhibit) begin
                        w_next_mask = 1'b1;
                    end
                end else begin
                    // Wrap: pending slot takes priority, then a same-cycle bypass, else stop.
                    w_next_time = '0;
                    w_next_mask = 1'b0;
                    if (w_full) begin
                        w_pop         = 1'b1;
                        w_load_active = 1'b1;
                    end else if (w_transfer) begin
                        w_load_active = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_time   <= '0;
            r_mask   <= 1'b0;
            r_active <= '0;
        end else begin
            r_state <= w_next_state;
            r_time  <= w_next_time;
            r_mask  <= w_next_mask;
            if (w_load_active) begin
                r_active <= w_sel_data;
            end
        end
    end

    // Times at or beyond TIME_PERIOD can never equal r_time, so they never fire.
    for (genvar g = 0; g < NEURONS; g++) begin : g_cmp
        assign w_match[g] = (r_active[g*TW +: TW] == r_time);
    end

    assign enc.in_ready     = w_ready;
    assign enc.time_val     = r_time;
    assign enc.busy         = (r_state == RUN);
    assign enc.spike_volley = ((r_state == RUN) && !r_mask) ? w_match : '0;
    assign enc.period_start = (r_state == RUN) && (r_time == '0);
    assign enc.period_end   = (r_state == RUN) && w_last;

endmodule
